// File: rtl/board_store_clear_if.sv
`default_nettype none
// ============================================================================
//  Module   : board_store_clear_if
//  Purpose  : Bundles the engine port, the renderer print port and the
//             line-clear handshake of the board store into one interface.
//  Modports : master - game engine / renderer side (drives indices, data,
//                      write_enable, clear_start)
//             slave  - board store side (drives read data, line_full,
//                      write_ready and the clear status)
//  Signals  : pos_i, pos_j, write_enable, write_data, output_data,
//             write_ready, print_i, print_j, print_data, line_full,
//             clear_start, clear_busy, clear_done, lines_cleared
//  Revision : 1.0 - initial release
// ============================================================================
interface board_store_clear_if #(
    parameter int WIDTH     = 10,
    parameter int HEIGHT    = 20,
    parameter int CELL_BITS = 3,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 5
);
    localparam int c_LC_BITS = $clog2(HEIGHT + 1);

    logic [ROW_BITS-1:0]  pos_i;
    logic [COL_BITS-1:0]  pos_j;
    logic                 write_enable;
    logic [CELL_BITS-1:0] write_data;
    logic [CELL_BITS-1:0] output_data;
    logic                 write_ready;
    logic [ROW_BITS-1:0]  print_i;
    logic [COL_BITS-1:0]  print_j;
    logic [CELL_BITS-1:0] print_data;
    logic [HEIGHT-1:0]    line_full;
    logic                 clear_start;
    logic                 clear_busy;
    logic                 clear_done;
    logic [c_LC_BITS-1:0] lines_cleared;

    modport master (
        output pos_i, pos_j, write_enable, write_data,
        output print_i, print_j, clear_start,
        input  output_data, write_ready, print_data, line_full,
        input  clear_busy, clear_done, lines_cleared
    );

    modport slave (
        input  pos_i, pos_j, write_enable, write_data,
        input  print_i, print_j, clear_start,
        output output_data, write_ready, print_data, line_full,
        output clear_busy, clear_done, lines_cleared
    );
endinterface
`default_nettype wire

// File: rtl/board_store_clear.sv
`default_nettype none
// ============================================================================
//  Module   : board_store_clear
//  Purpose  : HEIGHT x WIDTH Tetris board store with a random read/write
//             engine port, an always-live print port for the renderer, per-row
//             occupancy counts driving line_full, and a line-clear engine that
//             removes full rows and compacts the rows above them downward.
//  Ports    : clk   - clock, all state on the rising edge
//             reset - asynchronous active-low reset
//             bus   - board_store_clear_if.slave (engine, print, clear ports)
//  Revision : 1.0 - initial release
// ============================================================================
module board_store_clear #(
    parameter int WIDTH     = 10,
    parameter int HEIGHT    = 20,
    parameter int CELL_BITS = 3,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 5
) (
    input  wire logic          clk,
    input  wire logic          reset,
    board_store_clear_if.slave bus
);
    localparam int                  c_CNT_BITS   = $clog2(WIDTH + 1);
    localparam int                  c_LC_BITS    = $clog2(HEIGHT + 1);
    localparam logic [c_CNT_BITS-1:0] c_FULL_COUNT = c_CNT_BITS'(WIDTH);
    localparam logic [ROW_BITS-1:0] c_LAST_ROW   = ROW_BITS'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPACT = 2'd1,
        S_FILL    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Board kept fully packed so a whole row can be moved in one assignment.
    logic [HEIGHT-1:0][WIDTH-1:0][CELL_BITS-1:0] r_cells;
    logic [HEIGHT-1:0][c_CNT_BITS-1:0]           r_count;

    state_t                r_state;
    logic [HEIGHT-1:0]     r_full_snap;
    logic [ROW_BITS-1:0]   r_src;
    logic [ROW_BITS-1:0]   r_dst;
    logic [c_LC_BITS-1:0]  r_cleared;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_write_ready;
    logic [c_LC_BITS-1:0]  r_lines_cleared;

    logic [CELL_BITS-1:0]             w_out;
    logic [CELL_BITS-1:0]             w_print;
    logic                             w_wr_hit;
    logic [WIDTH-1:0][CELL_BITS-1:0]  w_src_row;
    logic [c_CNT_BITS-1:0]            w_src_count;
    logic                             w_src_full;
    logic [c_LC_BITS-1:0]             w_cleared_next;
    logic [HEIGHT-1:0]                w_line_full;

    // Read muxes are built by matching every legal (row, col) pair, so an
    // out-of-range index simply matches nothing and reads as NULL. The same
    // match tells the write path whether the engine index is on the board.
    always_comb begin
        w_out       = '0;
        w_print     = '0;
        w_wr_hit    = 1'b0;
        w_src_row   = '0;
        w_src_count = '0;
        w_src_full  = 1'b0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (r_src == ROW_BITS'(r)) begin
                w_src_row   = r_cells[r];
                w_src_count = r_count[r];
                w_src_full  = r_full_snap[r];
            end
            for (int c = 0; c < WIDTH; c++) begin
                if (bus.pos_i == ROW_BITS'(r) && bus.pos_j == COL_BITS'(c)) begin
                    w_out    = r_cells[r][c];
                    w_wr_hit = 1'b1;
                end
                if (bus.print_i == ROW_BITS'(r) && bus.print_j == COL_BITS'(c)) begin
                    w_print = r_cells[r][c];
                end
            end
        end
    end

    assign w_cleared_next = r_cleared + c_LC_BITS'(w_src_full);

    generate
        for (genvar g = 0; g < HEIGHT; g++) begin : g_line_full
            assign w_line_full[g] = (r_count[g] == c_FULL_COUNT);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cells         <= '0;
            r_count         <= '0;
            r_state         <= S_IDLE;
            r_full_snap     <= '0;
            r_src           <= '0;
            r_dst           <= '0;
            r_cleared       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_write_ready   <= 1'b1;
            r_lines_cleared <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.clear_start) begin
                        // Full rows are frozen here; compaction moves rows
                        // around, so live flags would no longer match src.
                        r_full_snap   <= w_line_full;
                        r_src         <= c_LAST_ROW;
                        r_dst         <= c_LAST_ROW;
                        r_cleared     <= '0;
                        r_busy        <= 1'b1;
                        r_write_ready <= 1'b0;
                        r_state       <= S_COMPACT;
                    end else if (bus.write_enable && w_wr_hit) begin
                        for (int r = 0; r < HEIGHT; r++) begin
                            if (bus.pos_i == ROW_BITS'(r)) begin
                                for (int c = 0; c < WIDTH; c++) begin
                                    if (bus.pos_j == COL_BITS'(c)) begin
                                        r_cells[r][c] <= bus.write_data;
                                    end
                                end
                                // w_out is the cell being replaced.
                                if (w_out == '0 && bus.write_data != '0) begin
                                    r_count[r] <= r_count[r] + c_CNT_BITS'(1);
                                end else if (w_out != '0 && bus.write_data == '0) begin
                                    r_count[r] <= r_count[r] - c_CNT_BITS'(1);
                                end
                            end
                        end
                    end
                end

                S_COMPACT: begin
                    // dst only advances past rows that survive, so it trails
                    // src by the number of rows dropped so far.
                    if (!w_src_full) begin
                        for (int r = 0; r < HEIGHT; r++) begin
                            if (r_dst == ROW_BITS'(r)) begin
                                r_cells[r] <= w_src_row;
                                r_count[r] <= w_src_count;
                            end
                        end
                        r_dst <= r_dst - ROW_BITS'(1);
                    end
                    r_cleared <= w_cleared_next;
                    r_src     <= r_src - ROW_BITS'(1);
                    if (r_src == '0) begin
                        r_state <= (w_cleared_next != '0) ? S_FILL : S_DONE;
                    end
                end

                S_FILL: begin
                    // Rows cleared-1 down to 0 are now stale copies; blank them.
                    for (int r = 0; r < HEIGHT; r++) begin
                        if (r_dst == ROW_BITS'(r)) begin
                            r_cells[r] <= '0;
                            r_count[r] <= '0;
                        end
                    end
                    r_dst <= r_dst - ROW_BITS'(1);
                    if (r_dst == '0) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done          <= 1'b1;
                    r_lines_cleared <= r_cleared;
                    r_busy          <= 1'b0;
                    r_write_ready   <= 1'b1;
                    r_state         <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.output_data   = w_out;
    assign bus.print_data    = w_print;
    assign bus.line_full     = w_line_full;
    assign bus.write_ready   = r_write_ready;
    assign bus.clear_busy    = r_busy;
    assign bus.clear_done    = r_done;
    assign bus.lines_cleared = r_lines_cleared;

endmodule
`default_nettype wire

// File: tb/tb_board_store_clear.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_store_clear
//  Purpose  : Self-checking bench for board_store_clear. A behavioural board
//             model (plain 2-D array, whole-pass clear result, busy countdown)
//             is compared against the DUT on every falling edge, and directed
//             sequences add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_store_clear;
    localparam int WIDTH     = 10;
    localparam int HEIGHT    = 20;
    localparam int CELL_BITS = 3;
    localparam int ROW_BITS  = 5;
    localparam int COL_BITS  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    board_store_clear_if #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CELL_BITS(CELL_BITS),
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)
    ) bus ();

    board_store_clear #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CELL_BITS(CELL_BITS),
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int m_board [HEIGHT][WIDTH];
    int m_next  [HEIGHT][WIDTH];
    int m_busy      = 0;
    int m_done      = 0;
    int m_lc        = 0;
    int m_pending   = 0;
    int m_busy_left = 0;
    int p_idx       = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_read(input int i, input int j);
        if (i < HEIGHT && j < WIDTH) return m_board[i][j];
        return 0;
    endfunction

    function automatic int model_full();
        int full = 0;
        for (int r = 0; r < HEIGHT; r++) begin
            int occ = 0;
            for (int c = 0; c < WIDTH; c++) if (m_board[r][c] != 0) occ++;
            if (occ == WIDTH) full |= (1 << r);
        end
        return full;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++) m_board[r][c] = 0;
        m_busy = 0; m_done = 0; m_lc = 0; m_busy_left = 0; m_pending = 0;
    endtask

    // Advance the model by one rising edge using the inputs the DUT sampled.
    task automatic model_step();
        if (!reset) return;
        m_done = 0;
        if (m_busy != 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_board = m_next;
                m_lc    = m_pending;
                m_done  = 1;
                m_busy  = 0;
            end
        end else if (bus.clear_start) begin
            int full = model_full();
            int k    = 0;
            int dst  = HEIGHT - 1;
            for (int r = 0; r < HEIGHT; r++)
                for (int c = 0; c < WIDTH; c++) m_next[r][c] = 0;
            for (int r = HEIGHT - 1; r >= 0; r--) begin
                if (full[r]) k++;
                else begin
                    m_next[dst] = m_board[r];
                    dst--;
                end
            end
            m_pending   = k;
            m_busy_left = HEIGHT + k + 1;
            m_busy      = 1;
        end else if (bus.write_enable && int'(bus.pos_i) < HEIGHT && int'(bus.pos_j) < WIDTH) begin
            m_board[bus.pos_i][bus.pos_j] = int'(bus.write_data);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("clear_busy",    int'(bus.clear_busy),    m_busy);
        check("clear_done",    int'(bus.clear_done),    m_done);
        check("lines_cleared", int'(bus.lines_cleared), m_lc);
        check("write_ready",   int'(bus.write_ready),   (m_busy == 0) ? 1 : 0);
        if (m_busy == 0) begin
            check("output_data", int'(bus.output_data),
                  model_read(int'(bus.pos_i), int'(bus.pos_j)));
            check("print_data", int'(bus.print_data),
                  model_read(int'(bus.print_i), int'(bus.print_j)));
            check("line_full", int'(bus.line_full), model_full());
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        // Renderer scans rows 0..21 and cols 0..10, covering out-of-range reads.
        p_idx       = (p_idx + 1) % (22 * 11);
        bus.print_i = ROW_BITS'(p_idx / 11);
        bus.print_j = COL_BITS'(p_idx % 11);
    endtask

    task automatic wr(input int i, input int j, input int d);
        bus.pos_i        = ROW_BITS'(i);
        bus.pos_j        = COL_BITS'(j);
        bus.write_data   = CELL_BITS'(d);
        bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
    endtask

    task automatic rd(input string name, input int i, input int j, input int exp);
        bus.pos_i = ROW_BITS'(i);
        bus.pos_j = COL_BITS'(j);
        tick();
        check(name, int'(bus.output_data), exp);
    endtask

    task automatic fill_row(input int r, input int skip);
        for (int j = 0; j < WIDTH; j++) if (j != skip) wr(r, j, 1 + ((r + j) % 7));
    endtask

    task automatic clear_row(input int r);
        for (int j = 0; j < WIDTH; j++) wr(r, j, 0);
    endtask

    task automatic run_clear(output int n);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        n = 0;
        while (!bus.clear_done && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        bus.pos_i = '0; bus.pos_j = '0; bus.write_enable = 1'b0; bus.write_data = '0;
        bus.print_i = '0; bus.print_j = '0; bus.clear_start = 1'b0;
        model_reset();

        // 1: reset
        #1 reset = 1'b0;
        #1;
        check("rst_busy",      int'(bus.clear_busy), 0);
        check("rst_done",      int'(bus.clear_done), 0);
        check("rst_line_full", int'(bus.line_full),  0);
        check("rst_out",       int'(bus.output_data), 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_write_ready", int'(bus.write_ready), 1);
        check("rst_lines",       int'(bus.lines_cleared), 0);

        // 2: writes, count up/down, out-of-range
        wr(5, 2, 3);
        rd("w52_3", 5, 2, 3);
        wr(5, 2, 0);
        rd("w52_0", 5, 2, 0);
        fill_row(5, -1);
        check("row5_full", int'(bus.line_full), 32'h20);
        wr(5, 2, 0);
        check("row5_dec", int'(bus.line_full), 0);
        wr(5, 2, 3);
        check("row5_inc", int'(bus.line_full), 32'h20);
        clear_row(5);
        check("row5_empty", int'(bus.line_full), 0);
        wr(25, 2, 4);
        rd("oor_row", 25, 2, 0);
        rd("oor_col", 5, 10, 0);
        check("oor_line_full", int'(bus.line_full), 0);

        // 3: overwrite keeps count
        wr(7, 7, 3);
        wr(7, 7, 6);
        rd("ovr_77", 7, 7, 6);
        fill_row(7, 7);
        check("row7_full", int'(bus.line_full), 32'h80);
        clear_row(7);

        // 4: single clear
        fill_row(19, -1);
        wr(18, 0, 2);
        check("pre1_full", int'(bus.line_full), 32'h80000);
        run_clear(n);
        check("clr1_latency", n, 22);
        check("clr1_lines", int'(bus.lines_cleared), 1);
        rd("clr1_19_0", 19, 0, 2);
        rd("clr1_18_0", 18, 0, 0);
        for (int j = 0; j < WIDTH; j++) rd("clr1_row0", 0, j, 0);
        check("clr1_full", int'(bus.line_full), 0);

        // 5: multi clear
        fill_row(19, -1);
        wr(18, 4, 5);
        fill_row(17, -1);
        wr(16, 4, 3);
        check("pre2_full", int'(bus.line_full), 32'hA0000);
        run_clear(n);
        check("clr2_latency", n, 23);
        check("clr2_lines", int'(bus.lines_cleared), 2);
        rd("clr2_19_4", 19, 4, 5);
        rd("clr2_18_4", 18, 4, 3);
        rd("clr2_17_4", 17, 4, 0);
        rd("clr2_1_4", 1, 4, 0);

        // zero-row pass
        run_clear(n);
        check("clr0_latency", n, 21);
        check("clr0_lines", int'(bus.lines_cleared), 0);
        rd("clr0_19_4", 19, 4, 5);

        // 6: interference during busy
        fill_row(19, 4);
        check("pre3_full", int'(bus.line_full), 32'h80000);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        check("busy_wr_ready", int'(bus.write_ready), 0);
        check("busy_flag", int'(bus.clear_busy), 1);
        wr(0, 0, 7);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        n = 2;
        while (!bus.clear_done && n < 200) begin
            tick();
            n++;
        end
        check("clr3_latency", n, 22);
        check("clr3_lines", int'(bus.lines_cleared), 1);
        rd("busy_wr_dropped", 0, 0, 0);
        rd("clr3_19_4", 19, 4, 3);

        // reset mid-COMPACT
        fill_row(19, -1);
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        bus.pos_i = ROW_BITS'(19);
        bus.pos_j = COL_BITS'(0);
        reset = 1'b0;
        model_reset();
        #1;
        check("abort_busy", int'(bus.clear_busy), 0);
        check("abort_out",  int'(bus.output_data), 0);
        check("abort_full", int'(bus.line_full), 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("abort_wr_ready", int'(bus.write_ready), 1);
        rd("abort_19_4", 19, 4, 0);
        rd("abort_18_4", 18, 4, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
